// File: rtl/serial_multiplier_pkg.sv
// Shared definitions for the serial shift-and-add multiply-accumulate unit.
package serial_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int N     = 8;
  localparam int LOG2N = 3;

endpackage

// File: rtl/serial_multiplier_if.sv
// go/done handshake, operands and product of the serial multiplier.
interface serial_multiplier_if
  import serial_multiplier_pkg::*;
#(
  parameter int n = N
);

  logic             go;
  logic [n-1:0]     multiplicand;
  logic [n-1:0]     multiplier;
  logic [n-1:0]     addend;
  logic [2*n-1:0]   product;
  logic             done;

  modport master (
    output go, multiplicand, multiplier, addend,
    input  product, done
  );

  modport slave (
    input  go, multiplicand, multiplier, addend,
    output product, done
  );

endinterface

// File: rtl/serial_multiplier_shift_right_accumulator.sv
// hi/lo accumulator with stored multiplicand; retires one multiplier bit per shift.
module serial_multiplier_shift_right_accumulator
  import serial_multiplier_pkg::*;
#(
  parameter int n = N
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           load,
  input  logic           shift,
  input  logic [n-1:0]   multiplicand,
  input  logic [n-1:0]   multiplier,
  input  logic [n-1:0]   addend,
  output logic [2*n-1:0] product
);

  logic [n-1:0] hi_q;
  logic [n-1:0] lo_q;
  logic [n-1:0] mcand_q;
  logic [n:0]   sum;

  // The carry lands in the top bit of hi after the shift, so it is never lost.
  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
    end else if (load) begin
      hi_q    <= addend;
      lo_q    <= multiplier;
      mcand_q <= multiplicand;
    end else if (shift) begin
      hi_q <= sum[n:1];
      lo_q <= {sum[0], lo_q[n-1:1]};
    end
  end

  assign product = {hi_q, lo_q};

endmodule

// File: rtl/serial_multiplier.sv
// Unsigned serial multiply-accumulate: product = multiplicand * multiplier + addend.
module serial_multiplier
  import serial_multiplier_pkg::*;
#(
  parameter int n     = N,
  parameter int log2n = LOG2N
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clken,
  serial_multiplier_if.slave  bus
);

  localparam logic [log2n-1:0] CNT_INIT = log2n'(n - 1);

  state_t           state_q;
  state_t           state_d;
  logic [log2n-1:0] cnt_q;
  logic             load;
  logic             shift;
  logic             done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= CNT_INIT;
    end else if (clken) begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= CNT_INIT;
      end else if (shift) begin
        cnt_q <= cnt_q - log2n'(1);
      end
    end
  end

  // IDLE reloads operands every edge so the edge leaving IDLE samples them.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        load = 1'b1;
        if (bus.go) state_d = RUN;
      end
      RUN: begin
        shift = 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!bus.go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  serial_multiplier_shift_right_accumulator #(
    .n (n)
  ) u_shift_right_accumulator (
    .clk          (clk),
    .resetn       (resetn),
    .load         (load & clken),
    .shift        (shift & clken),
    .multiplicand (bus.multiplicand),
    .multiplier   (bus.multiplier),
    .addend       (bus.addend),
    .product      (bus.product)
  );

  assign bus.done = done;

endmodule

// File: tb/tb_serial_multiplier.sv
// Directed and randomised checks of the serial multiply-accumulate unit.
module tb_serial_multiplier;

  logic clk;
  logic resetn;
  logic clken;
  int   checks;
  int   failures;
  int   edges;

  serial_multiplier_if #(.n(8)) bus ();

  serial_multiplier #(.n(8), .log2n(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .clken  (clken),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.addend       = c;
  endtask

  // Counts clock edges (the go-sampling edge is edge 1) until done, from a negedge.
  task automatic wait_done(input int start, output int n_edges);
    n_edges = start;
    while (bus.done !== 1'b1 && n_edges < 100) begin
      @(negedge clk);
      n_edges++;
    end
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL wait_done timeout observed=done_low expected=done_high");
    end
  endtask

  task automatic finish_op();
    bus.go = 1'b0;
    @(negedge clk);
    check("done_clears", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [15:0] exp);
    int n_edges;
    @(negedge clk);
    set_ops(a, b, c);
    bus.go = 1'b1;
    wait_done(0, n_edges);
    check({tag, "_latency"}, n_edges, 32'd9);
    check({tag, "_product"}, {16'd0, bus.product}, {16'd0, exp});
    finish_op();
  endtask

  initial begin
    logic [7:0]  ra, rb, rc;
    logic [15:0] rexp;
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    clken    = 1'b1;
    bus.go   = 1'b0;
    set_ops(8'd0, 8'd0, 8'd0);
    #12;
    check("reset_product", {16'd0, bus.product}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // 13*11+0 with go held past done: result must stay put.
    @(negedge clk);
    set_ops(8'd13, 8'd11, 8'd0);
    bus.go = 1'b1;
    wait_done(0, edges);
    check("basic_latency", edges, 32'd9);
    check("basic_product", {16'd0, bus.product}, 32'h008F);
    set_ops(8'd1, 8'd2, 8'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_done", {31'd0, bus.done}, 32'd1);
      check("hold_product", {16'd0, bus.product}, 32'h008F);
    end
    finish_op();
    run_op("after_hold", 8'd3, 8'd4, 8'd5, 16'd17);

    run_op("max_acc", 8'd255, 8'd255, 8'd255, 16'hFF00);
    run_op("max_mul", 8'd255, 8'd255, 8'd0, 16'hFE01);
    run_op("zero_b", 8'd200, 8'd0, 8'd7, 16'h0007);
    run_op("zero_a", 8'd0, 8'd99, 8'd200, 16'h00C8);

    // clken low for 3 cycles in the middle of RUN; operands changed mid-run too.
    @(negedge clk);
    set_ops(8'd100, 8'd37, 8'd12);
    bus.go = 1'b1;
    repeat (3) @(negedge clk);
    set_ops(8'd9, 8'd9, 8'd9);
    clken = 1'b0;
    repeat (3) @(negedge clk);
    clken = 1'b1;
    wait_done(6, edges);
    check("clken_latency", edges, 32'd12);
    check("clken_product", {16'd0, bus.product}, 32'h0E80);
    finish_op();

    // Asynchronous reset during RUN cycle 4.
    @(negedge clk);
    set_ops(8'd50, 8'd60, 8'd70);
    bus.go = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("midrun_reset_product", {16'd0, bus.product}, 32'd0);
    check("midrun_reset_done", {31'd0, bus.done}, 32'd0);
    bus.go = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_op("post_reset", 8'd6, 8'd7, 8'd1, 16'd43);

    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 8'($urandom);
      rexp = 16'(ra) * 16'(rb) + 16'(rc);
      run_op("random", ra, rb, rc, rexp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
